if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage_if_id_reg.sv | 49 ++++
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset PC default,
// PC increment and the word-alignment helper.
// Latency: none (types and constants only). Backpressure: n/a.
package if_stage_pkg;

  // IDLE: nothing outstanding, WAIT: one request in flight, DROP: in-flight response is stale
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } if_state_e;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC      = 32'd4;

  // Instruction addresses are word aligned; the low two bits are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction memory request/response plus the IF/ID handshake.
// Latency: none (wiring only). Backpressure: id_ready is the consumer's accept signal.
// Ports: master = fetch stage (drives imem_req/addr and id_*), slave = memory + decode side.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    input  imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4,
    output imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction with its pc and pc+4.
// Latency: load appears on outputs the cycle after i_load.
// Backpressure: contents held stable until i_consume; i_flush wins over load and consume.
// Ports: clk, rst_n, i_load/i_instr/i_pc/i_pc_plus4 (new entry), i_consume, i_flush,
//        o_valid/o_instr/o_pc/o_pc_plus4 (register contents).
module if_id_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_consume,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, redirect flush, IF/ID register.
// Latency: request at N, response at N+k, id_valid at N+k+1; at most 1 instr per 2 cycles.
// Backpressure: no new request while IF/ID is full and not being consumed (id_ready low).
// Ports: clk, rst_n, run (fetch enable), redirect/redirect_pc (flush + new pc),
//        bus (if_stage_if.master: imem_* request/response, id_* handshake).
// Optional: define IF_PERF_CNT_EN to add fetch_cnt/flush_cnt performance counter outputs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  if_stage_if.master   bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_cnt,
  output logic [31:0]  flush_cnt
`endif
);

  if_state_e   r_state;
  if_state_e   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;
  logic        w_req;
  logic        w_load;
  logic        w_slot_free;

  assign w_pc_plus4  = r_pc + PC_INC;
  // The IF/ID slot is free if empty or being drained this cycle, so the response
  // (earliest next cycle) always finds room.
  assign w_slot_free = !bus.id_valid || bus.id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req       = 1'b0;
    w_load      = 1'b0;
    if (redirect) begin
      // Redirect overrides everything: new pc, no request, any response this cycle is dropped.
      w_pc_nxt = align_pc(redirect_pc);
      case (r_state)
        ST_WAIT: w_state_nxt = bus.imem_rvalid ? ST_IDLE : ST_DROP;
        // A response landing together with a redirect in DROP is the stale one; nothing
        // remains outstanding afterwards.
        ST_DROP: w_state_nxt = bus.imem_rvalid ? ST_IDLE : ST_DROP;
        default: w_state_nxt = ST_IDLE;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run && w_slot_free) begin
            w_req       = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            w_load      = 1'b1;
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DROP: begin
          if (bus.imem_rvalid) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Gate with rst_n so the pulse cannot appear combinationally while reset is held.
  assign bus.imem_req  = w_req && rst_n;
  assign bus.imem_addr = bus.imem_req ? r_pc : '0;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_instr    (bus.imem_rdata),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .i_consume  (bus.id_ready),
    .i_flush    (redirect),
    .o_valid    (bus.id_valid),
    .o_instr    (bus.id_instr),
    .o_pc       (bus.id_pc),
    .o_pc_plus4 (bus.id_pc_plus4)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_fetch_cnt <= r_fetch_cnt + {31'd0, w_load};
      r_flush_cnt <= r_flush_cnt + {31'd0, redirect};
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: driver with memory model, transaction-level reference model,
// and a negedge monitor that compares DUT outputs against the expectation queue.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  if_stage_if bus ();

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];          // expected IF/ID contents (0 or 1 entries)
  logic [31:0] m_pc;          // address the next request must carry
  bit          m_out;         // a request is outstanding
  bit          m_stale;       // outstanding response must be discarded
  logic [31:0] m_out_addr;
  int          m_cnt;
  int          m_fetch, m_flush;

  // knobs written by the sequence process only
  int          k_min = 1, k_max = 1;
  int          p_run = 100, p_ready = 100, p_redir = 0;
  bit          f_rst = 1'b1, f_redir = 1'b0, f_stale = 1'b0;
  logic [31:0] f_redir_pc = '0;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Driver + memory model + reference model update
  initial begin : driver
    bit          pv_rstn, pv_req, pv_redir, pv_rvalid, rv;
    logic [31:0] pv_rpc;
    int          pv_k;
    rst_n = 1'b0; run = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b0;
    m_pc = RST_PC; m_out = 0; m_stale = 0; m_out_addr = '0; m_cnt = 0;
    m_fetch = 0; m_flush = 0;
    pv_rstn = 0; pv_req = 0; pv_redir = 0; pv_rvalid = 0; pv_rpc = '0; pv_k = 1;
    forever begin
      @(posedge clk);
      // apply the effects of the cycle that just ended
      if (!pv_rstn) begin
        m_pc = RST_PC; m_out = 0; m_stale = 0; q.delete(); m_fetch = 0; m_flush = 0;
      end else begin
        if (pv_rvalid && m_out) begin
          if (!pv_redir && !m_stale) begin
            q.push_back('{pc: m_out_addr, instr: tag(m_out_addr)});
            m_pc = m_out_addr + 32'd4;
            m_fetch++;
          end
          m_out = 0; m_stale = 0;
        end
        if (pv_redir) begin
          m_pc = {pv_rpc[31:2], 2'b00};
          m_flush++;
          q.delete();
          if (m_out) m_stale = 1;
        end
        if (pv_req) begin
          m_out = 1; m_stale = 0; m_out_addr = m_pc; m_cnt = pv_k;
        end
      end
      // memory response schedule
      rv = m_out && (m_cnt <= 1);
      if (m_out && m_cnt > 1) m_cnt--;
      if (f_stale) rv = 1'b1;
      #1;
      rst_n           = !f_rst;
      run             = ($urandom_range(99, 0) < p_run);
      bus.id_ready    = ($urandom_range(99, 0) < p_ready);
      redirect        = f_redir || ($urandom_range(99, 0) < p_redir);
      redirect_pc     = f_redir ? f_redir_pc : $urandom;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? tag(m_out_addr) : $urandom;
      #1;
      pv_rstn   = rst_n;
      pv_req    = bus.imem_req && rst_n;
      pv_redir  = redirect && rst_n;
      pv_rvalid = rv && rst_n;
      pv_rpc    = redirect_pc;
      pv_k      = $urandom_range(k_max, k_min);
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    bit exp_req;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_imem_req",  {31'd0, bus.imem_req}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, 32'd0);
        chk("rst_id_valid",  {31'd0, bus.id_valid}, 32'd0);
        chk("rst_id_instr",  bus.id_instr, 32'd0);
        chk("rst_id_pc",     bus.id_pc, 32'd0);
        chk("rst_id_pc4",    bus.id_pc_plus4, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
      end else begin
        exp_req = !m_out && run && !redirect && (q.size() == 0 || bus.id_ready);
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        if (bus.imem_req) chk("imem_addr", bus.imem_addr, m_pc);
        chk("id_valid", {31'd0, bus.id_valid}, {31'd0, q.size() != 0});
        if (bus.id_valid && q.size() != 0) begin
          chk("id_pc",       bus.id_pc, q[0].pc);
          chk("id_instr",    bus.id_instr, q[0].instr);
          chk("id_pc_plus4", bus.id_pc_plus4, q[0].pc + 32'd4);
          if (bus.id_ready) void'(q.pop_front());
        end
      end
    end
  end

  // Sequence
  initial begin : sequencer
    int i;
    // reset, then straight-line fetch with 1-cycle memory (includes pc wrap from RST_PC)
    repeat (3) @(negedge clk);
    f_rst = 1'b0;
    repeat (20) @(negedge clk);

    // decode stall
    p_ready = 0;
    repeat (6) @(negedge clk);
    p_ready = 100;
    repeat (6) @(negedge clk);

    // redirect while waiting on a 3-cycle memory
    k_min = 3; k_max = 3;
    repeat (4) @(negedge clk);
    for (i = 0; i < 50 && !(m_out && !m_stale && m_cnt >= 2); i++) @(negedge clk);
    if (!(m_out && !m_stale && m_cnt >= 2)) timeout("wait_for_wait_state");
    f_redir_pc = 32'h0000_0103;
    f_redir = 1'b1;
    @(negedge clk);
    f_redir = 1'b0;
    for (i = 0; i < 50 && !bus.imem_req; i++) @(negedge clk);
    if (bus.imem_req) chk("redir_addr", bus.imem_addr, 32'h0000_0100);
    else timeout("redir_req");
    repeat (10) @(negedge clk);

    // redirect coincident with the response
    k_min = 1; k_max = 1;
    for (i = 0; i < 50 && !bus.imem_req; i++) @(negedge clk);
    if (!bus.imem_req) timeout("coincident_req");
    f_redir_pc = 32'h0000_0200;
    f_redir = 1'b1;
    @(negedge clk);
    f_redir = 1'b0;
    @(negedge clk);
    chk("coincident_no_valid", {31'd0, bus.id_valid}, 32'd0);
    repeat (8) @(negedge clk);

    // reset mid-WAIT, then a stale response while idle
    k_min = 3; k_max = 3;
    for (i = 0; i < 50 && !(m_out && !m_stale); i++) @(negedge clk);
    if (!(m_out && !m_stale)) timeout("wait_before_reset");
    f_rst = 1'b1;
    repeat (2) @(negedge clk);
    p_run = 0;
    f_rst = 1'b0;
    @(negedge clk);
    f_stale = 1'b1;
    @(negedge clk);
    f_stale = 1'b0;
    @(negedge clk);
    chk("stale_ignored", {31'd0, bus.id_valid}, 32'd0);
    p_run = 100;
    k_min = 1; k_max = 1;
    for (i = 0; i < 20 && !bus.imem_req; i++) @(negedge clk);
    if (bus.imem_req) chk("post_reset_addr", bus.imem_addr, RST_PC);
    else timeout("post_reset_req");
    for (i = 0; i < 20 && !bus.id_valid; i++) @(negedge clk);
    if (bus.id_valid) chk("post_reset_id_pc", bus.id_pc, RST_PC);
    else timeout("post_reset_valid");
    repeat (10) @(negedge clk);

    // randomized traffic
    k_min = 1; k_max = 4;
    p_run = 90; p_ready = 70; p_redir = 5;
    repeat (3000) @(negedge clk);

    // drain
    p_run = 0; p_ready = 100; p_redir = 0;
    for (i = 0; i < 40 && (m_out || q.size() != 0); i++) @(negedge clk);
    if (m_out || q.size() != 0) timeout("drain");
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
